// File: rtl/boot_loader.sv
// Copies COUNT words from the flash ROM controller into RAM after reset, keeping the CPU
// in reset until the copy finishes or a ROM read times out.
module boot_loader #(
    parameter int WIDTH    = 16,
    parameter int ROM_ADDR = 23,
    parameter int RAM_ADDR = 13,
    parameter int SRC_BASE = 0,
    parameter int COUNT    = 8192,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [ROM_ADDR-1:0] rom_addr,
    output logic                rom_load,
    input  logic [WIDTH-1:0]    rom_data,
    input  logic                rom_ready,
    output logic [RAM_ADDR-1:0] ram_addr,
    output logic [WIDTH-1:0]    ram_din,
    output logic                ram_we,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WIDTH-1:0]    checksum,
    output logic                cpu_hold
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FIN} state_t;

    localparam logic [31:0]         LAST_IDX  = (COUNT > 0) ? 32'(COUNT - 1) : 32'd0;
    localparam logic [31:0]         TIMEOUT_W = 32'(TIMEOUT);
    localparam logic [ROM_ADDR-1:0] SRC       = ROM_ADDR'(SRC_BASE);

    state_t      state;
    logic [31:0] index;
    logic [31:0] wait_cnt;
    logic [31:0] next_index;
    logic [31:0] next_wait;

    assign next_index = index + 32'd1;
    assign next_wait  = wait_cnt + 32'd1;

    // rom_load and ram_we are one-cycle pulses that are raised on entry to REQ/WRITE,
    // so the ROM address and RAM write fields are always registered together with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            wait_cnt <= '0;
            rom_addr <= '0;
            rom_load <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            checksum <= '0;
            cpu_hold <= 1'b1;
        end else begin
            rom_load <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (COUNT == 0) begin
                            state    <= FIN;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= REQ;
                            index    <= '0;
                            rom_addr <= SRC;
                            rom_load <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                // Ready is only trusted here; in the load cycle it still reflects the previous read.
                WAIT: begin
                    if (rom_ready) begin
                        ram_din  <= rom_data;
                        ram_addr <= index[RAM_ADDR-1:0];
                        ram_we   <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        wait_cnt <= next_wait;
                        if (next_wait >= TIMEOUT_W) begin
                            error    <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
                            state    <= FIN;
                        end
                    end
                end
                WRITE: begin
                    checksum <= checksum + ram_din;
                    if (index == LAST_IDX) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                        state    <= FIN;
                    end else begin
                        index    <= next_index;
                        rom_addr <= SRC + next_index[ROM_ADDR-1:0];
                        rom_load <= 1'b1;
                        state    <= REQ;
                    end
                end
                FIN: begin
                    state <= FIN;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 16, data word width.
- ROM_ADDR, default 23, ROM word-address width.
- RAM_ADDR, default 13, RAM word-address width.
- SRC_BASE, default 0, first ROM word address copied.
- COUNT, default 8192, number of words copied (0 allowed).
- TIMEOUT, default 255, maximum wait cycles per word.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a copy; sampled in IDLE only.
- rom_addr  out  ROM_ADDR  word address to the flash ROM controller.
- rom_load  out  1  one-cycle load strobe to the ROM controller.
- rom_data  in  WIDTH  ROM controller data.
- rom_ready  in  1  ROM controller ready.
- ram_addr  out  RAM_ADDR  destination word address.
- ram_din  out  WIDTH  destination write data.
- ram_we  out  1  destination write strobe.
- busy  out  1  copy in progress.
- done  out  1  copy finished; sticky.
- error  out  1  timeout occurred; sticky.
- checksum  out  WIDTH  running sum of written words.
- cpu_hold  out  1  holds the processor in reset until done.
REQ-003 Clocking and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT, WRITE and FIN. All state and counter registers SHALL update on the rising edge of clk only.
REQ-005 In IDLE with start=1: if COUNT=0, go to FIN; otherwise go to REQ with the source index at 0.
REQ-006 In REQ: rom_load=1 and rom_addr=SRC_BASE+index for exactly one cycle, then go to WAIT with the wait counter at 0.
REQ-007 In WAIT, rom_ready SHALL be sampled. It SHALL never be sampled in the REQ cycle, because ready is stale in the cycle load is asserted.
REQ-008 In WAIT with rom_ready=1: capture rom_data into ram_din, then go to WRITE.
REQ-009 In WAIT with rom_ready=0: increment the wait counter. When the counter reaches TIMEOUT, set error=1 and go to FIN without writing.
REQ-010 In WRITE: ram_we=1 for exactly one cycle with ram_addr=index[RAM_ADDR-1:0] and ram_din holding the captured word.
REQ-011 In WRITE, checksum SHALL become (checksum+ram_din) mod 2^WIDTH.
REQ-012 In WRITE: if index=COUNT-1, go to FIN; otherwise increment index and go to REQ.
REQ-013 The source address SHALL wrap modulo 2^ROM_ADDR. The RAM address SHALL wrap modulo 2^RAM_ADDR.
REQ-014 In FIN: done=1, busy=0 and cpu_hold=0. FIN is terminal until reset, and start SHALL be ignored there.
REQ-015 Outside FIN, cpu_hold SHALL be 1.
REQ-016 busy SHALL be 1 in REQ, WAIT and WRITE, and 0 otherwise.
REQ-017 rom_load and ram_we SHALL never be asserted in the same cycle.
REQ-018 start asserted while busy SHALL have no effect.
REQ-019 Per-word latency SHALL be 1 (REQ) + N (WAIT, including the rom_ready cycle) + 1 (WRITE) cycles.
- With the ROM controller at P_MISS=4 this is 6 cycles.
- At P_HIT=2 this is 4 cycles.
REQ-020 rom_addr SHALL hold its last value outside REQ.

Reset
REQ-021 While rst_n=0, all outputs SHALL take these values:
- State = IDLE.
- busy=0, done=0, error=0.
- rom_load=0, ram_we=0.
- cpu_hold=1.
- checksum=0, index=0.
- rom_addr=0, ram_addr=0, ram_din=0.
REQ-022 Reset asserted mid-copy SHALL take effect immediately and asynchronously. No further rom_load or ram_we pulse SHALL occur.

Verification
REQ-023 Basic copy: COUNT=4, SRC_BASE=16, ROM model words 0x1111,0x2222,0x3333,0x4444, P_MISS=4 then P_HIT=2 (same page). Required response:
- RAM[0..3] = those words.
- checksum=0xAAAA.
- done=1 at cycle 6+4+4+4 after start.
- cpu_hold falls together with done.
REQ-024 Stale ready: the ROM model holds rom_ready=1 in the REQ cycle. Required response: the loader still waits for ready in WAIT; no write of stale data.
REQ-025 Timeout: TIMEOUT=10 and the ROM model never asserts ready. Required response:
- error=1 and done=1 exactly 1+10 cycles after the load pulse.
- ram_we never asserted.
REQ-026 COUNT=0: start=1. Required response: FIN the next cycle, done=1, no rom_load, checksum=0.
REQ-027 Reset mid-copy: rst_n low during WAIT of word 2. Required response:
- Outputs reach reset values without a clock edge.
- After release, start=1 recopies from SRC_BASE.
REQ-028 Start while busy and wrap: start pulsed during the copy is ignored. With RAM_ADDR=2 and COUNT=5, word 4 writes ram_addr=0, and checksum wraps modulo 2^16.
